mvm_ctrl: RTL
=============

# mvm_ctrl

Sequencing controller for the matrix-vector multiplication engine. On a start pulse it walks every (row, word) pair of the matrix and issues read addresses to the vector and matrix memories. It also generates the `valid`/`first`/`last` tags that travel with the returned data through the dot-product stage into the accumulator, delayed to line up with memory read data. It sits directly upstream of the dot-product/accumulator datapath and drives its control inputs.

## Interface
- `MAX_ROWS`, 64: largest supported row count.
- `MAX_WORDS`, 16: largest supported words per row (one word = one lane group of vector elements).
- `MEM_LAT`, 2: read latency of both memories, in cycles; legal range 1..4.
- `ROWW`, `$clog2(MAX_ROWS+1)`: row-count width.
- `WORDW`, `$clog2(MAX_WORDS+1)`: word-count width.
- `VADDRW`, `$clog2(MAX_WORDS)`: vector memory address width.
- `MADDRW`, `$clog2(MAX_ROWS*MAX_WORDS)`: matrix memory address width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `num_rows`  in  ROWW  rows this pass; captured with `start`.
- `num_words`  in  WORDW  words per row; captured with `start`.
- `rd_en`  out  1  read strobe to both memories.
- `vec_raddr`  out  VADDRW  vector word index.
- `mat_raddr`  out  MADDRW  matrix word address.
- `tag_valid`  out  1  read data valid this cycle (feeds accumulator `ivalid`).
- `tag_first`  out  1  first word of a row.
- `tag_last`  out  1  last word of a row.
- `tag_row`  out  ROWW  row index of current data.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: `start`=1 with both counts nonzero → RUN. `start`=1 with either count zero → ZERO.
  - ZERO: one cycle; `busy`=`done`=1; no reads issued → IDLE.
  - RUN: issues one read per cycle, no bubbles. Word counter `w` runs 0..num_words-1. Row counter `r` runs 0..num_rows-1. `mat_raddr` is a running counter starting at 0 and incrementing by 1 per read; no multiplier. After the final read (r=num_rows-1, w=num_words-1) → DRAIN.
  - DRAIN: waits for the tag pipeline to empty. `done` pulses in the cycle the final `tag_last` is output → IDLE next cycle.
- Read outputs in RUN: `rd_en`=1, `vec_raddr`=w, `mat_raddr`=r·num_words+w.
- Issue-side tags: first = (w==0), last = (w==num_words-1), row = r. All tags pass through a MEM_LAT-deep delay line together with `rd_en`. When num_words=1, first and last are asserted in the same cycle.
- `start` in any state other than IDLE is ignored. `num_rows`/`num_words` are ignored except in the `start` cycle.
- `rst` in any state: FSM → IDLE, counters → 0, delay line flushed. The first cycle after reset deasserts every output.

## Timing
- Reset values: `rd_en`, `tag_valid`, `tag_first`, `tag_last`, `busy`, `done` = 0; all address and row outputs = 0.
- All outputs are registered.
- With `start` sampled at edge T:
  - First read is issued in cycle T+1.
  - Final read is issued in cycle T+R·W.
- A tag issued with a read in cycle k appears on the `tag_*` outputs in cycle k+MEM_LAT. This is the cycle the memory data is valid.
- `done` is high in cycle T+R·W+MEM_LAT; `busy` is high from T+1 through that cycle inclusive.
- Outside RUN, `rd_en`=0 and address outputs hold their last value.
- A new `start` is accepted in the first IDLE cycle after `done`. The minimum gap is one cycle.

## Structure
- `mvm_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, ZERO);
  - the `MEM_LAT` legal-range constants;
  - a packed tag struct {valid, first, last, row}.
- Sub-module `tag_delay`: parameterised shift register of the tag struct, depth MEM_LAT, with synchronous flush on `rst`.

## Test plan
- R=2, W=3, MEM_LAT=2, `start` at cycle 0:
  - `mat_raddr` 0..5 in cycles 1..6; `vec_raddr` 0,1,2,0,1,2.
  - `tag_valid` in cycles 3..8; `tag_first` at 3 and 6; `tag_last` at 5 and 8; `tag_row` 0,0,0,1,1,1.
  - `done` at cycle 8 only; `busy` in cycles 1..8.
- R=3, W=1, MEM_LAT=1 → `tag_first`=`tag_last`=1 in cycles 2, 3, 4; `done` at cycle 4.
- R=0, W=5, `start` at cycle 0 → `busy`=`done`=1 in cycle 1 only; no `rd_en`, no `tag_valid`.
- `start` re-pulsed mid-RUN (R=4, W=4) → ignored; address sequence and `done` timing unchanged.
- `rst` asserted at cycle 5 of an R=4, W=4 pass → from cycle 6 all outputs are 0. A `start` at cycle 7 restarts cleanly from address 0.
- Back-to-back passes (R=1, W=2, then R=2, W=2) with second `start` in the first IDLE cycle → second pass's `mat_raddr` restarts at 0; two separate `done` pulses.

Source files
------------

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared types and constants for the matrix-vector sequencing controller.
//   state_t  controller FSM states
//   tag_t    control tag carried alongside memory read data {valid, first, last, row}
//   MEM_LAT_MIN/MAX  legal range of memory read latency
package mvm_pkg;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

   // Row field is sized for the largest supported row count; narrower
   // configurations zero-extend into it.
   localparam int TAG_MAX_ROWS = 64;
   localparam int TAG_ROWW     = $clog2(TAG_MAX_ROWS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      ZERO  = 2'd3
   } state_t;

   typedef struct packed {
      logic                valid;
      logic                first;
      logic                last;
      logic [TAG_ROWW-1:0] row;
   } tag_t;

endpackage

// File: rtl/mvm_ctrl_tag_delay.sv
// tag_delay: DEPTH-stage shift register of tag_t, flushed synchronously by rst.
//   clk, rst  clock and synchronous active-high reset
//   din       tag entering the line (issue side)
//   dout      tag leaving the line DEPTH cycles later
module tag_delay
   import mvm_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  tag_t din,
   output tag_t dout
);

   tag_t stage_reg [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= '0;
               else     stage_reg[gi] <= din;
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= '0;
               else     stage_reg[gi] <= stage_reg[gi-1];
            end
         end
      end
   endgenerate

   assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/mvm_ctrl.sv
// mvm_ctrl: walks every (row, word) pair of a matrix, issuing one read per
// cycle to the vector and matrix memories, and produces valid/first/last/row
// tags aligned with the returned read data.
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a pass (sampled in IDLE only)
//   num_rows, num_words   pass dimensions, captured with start
//   rd_en, vec_raddr, mat_raddr   memory read port
//   tag_valid/first/last/row      tags aligned to read data (MEM_LAT later)
//   busy, done            pass in progress / one-cycle completion pulse
module mvm_ctrl
   import mvm_pkg::*;
#(
   parameter int MAX_ROWS  = 64,
   parameter int MAX_WORDS = 16,
   parameter int MEM_LAT   = 2,
   parameter int ROWW      = $clog2(MAX_ROWS + 1),
   parameter int WORDW     = $clog2(MAX_WORDS + 1),
   parameter int VADDRW    = $clog2(MAX_WORDS),
   parameter int MADDRW    = $clog2(MAX_ROWS * MAX_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROWW-1:0]   num_rows,
   input  logic [WORDW-1:0]  num_words,
   output logic              rd_en,
   output logic [VADDRW-1:0] vec_raddr,
   output logic [MADDRW-1:0] mat_raddr,
   output logic              tag_valid,
   output logic              tag_first,
   output logic              tag_last,
   output logic [ROWW-1:0]   tag_row,
   output logic              busy,
   output logic              done
);

   generate
      if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
         $error("mvm_ctrl: MEM_LAT out of range");
      end
      if (ROWW > TAG_ROWW) begin : g_bad_rows
         $error("mvm_ctrl: MAX_ROWS exceeds tag row field");
      end
   endgenerate

   state_t              state_reg, state_next;
   logic [ROWW-1:0]     rows_reg, rows_next;
   logic [WORDW-1:0]    words_reg, words_next;
   logic [ROWW-1:0]     r_reg, r_next;
   logic [VADDRW-1:0]   w_reg, w_next;
   logic [MADDRW-1:0]   mat_reg, mat_next;
   logic                rd_reg, rd_next;
   tag_t                issue_reg, issue_next;
   logic                final_reg, final_next;   // issued read is the last of the pass
   logic                done_reg, done_next;
   logic                busy_reg, busy_next;
   logic                fin [MEM_LAT];           // final flag, fin[i] = final_reg delayed i
   tag_t                tag_out;

   logic w_last, r_last;
   assign w_last = (WORDW'(w_reg) == words_reg - WORDW'(1));
   assign r_last = (r_reg == rows_reg - ROWW'(1));

   always_comb begin
      state_next = state_reg;
      rows_next  = rows_reg;
      words_next = words_reg;
      r_next     = r_reg;
      w_next     = w_reg;
      mat_next   = mat_reg;
      rd_next    = 1'b0;
      issue_next = '0;
      final_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               rows_next  = num_rows;
               words_next = num_words;
               if (num_rows == '0 || num_words == '0) begin
                  state_next = ZERO;
               end else begin
                  state_next       = RUN;
                  rd_next          = 1'b1;
                  r_next           = '0;
                  w_next           = '0;
                  mat_next         = '0;
                  issue_next.valid = 1'b1;
                  issue_next.first = 1'b1;
                  issue_next.last  = (num_words == WORDW'(1));
                  final_next       = (num_words == WORDW'(1)) && (num_rows == ROWW'(1));
               end
            end
         end
         RUN: begin
            if (w_last && r_last) begin
               state_next = DRAIN;
            end else begin
               rd_next  = 1'b1;
               mat_next = mat_reg + MADDRW'(1);
               if (w_last) begin
                  w_next = '0;
                  r_next = r_reg + ROWW'(1);
               end else begin
                  w_next = w_reg + VADDRW'(1);
               end
               issue_next.valid = 1'b1;
               issue_next.first = w_last;
               issue_next.last  = (WORDW'(w_next) == words_reg - WORDW'(1));
               issue_next.row   = TAG_ROWW'(r_next);
               final_next       = issue_next.last && (r_next == rows_reg - ROWW'(1));
            end
         end
         DRAIN: begin
            // done_reg is high exactly when the final tag is on the outputs
            if (done_reg) state_next = IDLE;
         end
         ZERO: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      done_next = (state_next == ZERO) || fin[MEM_LAT-1];
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         rows_reg  <= '0;
         words_reg <= '0;
         r_reg     <= '0;
         w_reg     <= '0;
         mat_reg   <= '0;
         rd_reg    <= 1'b0;
         issue_reg <= '0;
         final_reg <= 1'b0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         rows_reg  <= rows_next;
         words_reg <= words_next;
         r_reg     <= r_next;
         w_reg     <= w_next;
         mat_reg   <= mat_next;
         rd_reg    <= rd_next;
         issue_reg <= issue_next;
         final_reg <= final_next;
         done_reg  <= done_next;
         busy_reg  <= busy_next;
      end
   end

   // Final-read flag pipeline, one stage shorter than the tag line so that
   // done can be registered and still coincide with the last tag.
   generate
      for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_fin
         if (gi == 0) begin : g_head
            assign fin[gi] = final_reg;
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (rst) fin[gi] <= 1'b0;
               else     fin[gi] <= fin[gi-1];
            end
         end
      end
   endgenerate

   tag_delay #(.DEPTH(MEM_LAT)) u_tag_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (issue_reg),
      .dout (tag_out)
   );

   assign rd_en     = rd_reg;
   assign vec_raddr = w_reg;
   assign mat_raddr = mat_reg;
   assign tag_valid = tag_out.valid;
   assign tag_first = tag_out.first;
   assign tag_last  = tag_out.last;
   assign tag_row   = ROWW'(tag_out.row);
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule
